// File: rtl/cpu_ahb_if.sv
// AHB-Lite slave wrapping a small two-stage RV32I core (instance cpu_top) for host load, run and readback.
// Optional CPU_AHB_ERROR_RESP_EN: unmapped or dropped IM/DM accesses answer with S_HRESP = 1.

module cpu_int_rf (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    input  logic        we_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  host_addr_i,
    output logic [31:0] host_data_o
);
    logic [31:0] REG_I [32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) REG_I[i] <= '0;
        end else if (we_i && rd_i != 5'd0) begin
            REG_I[rd_i] <= wdata_i;
        end
    end

    assign rs1_data_o = REG_I[rs1_i];
    assign rs2_data_o = REG_I[rs2_i];
    // Host view includes a write-back landing on the same edge.
    assign host_data_o = (we_i && rd_i != 5'd0 && rd_i == host_addr_i) ? wdata_i : REG_I[host_addr_i];
endmodule

module cpu_fp_rf (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  rs1_i,
    output logic [31:0] rs1_data_o,
    input  logic        we_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] wdata_i
);
    logic [31:0] REG_F [32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) REG_F[i] <= '0;
        end else if (we_i) begin
            REG_F[rd_i] <= wdata_i;
        end
    end

    assign rs1_data_o = REG_F[rs1_i];
endmodule

module cpu_id (
    input  logic        clk_i,
    input  logic        sys_rst_ni,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] dm_rdata_i,
    input  logic [4:0]  host_rf_addr_i,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        dm_we_o,
    output logic [10:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    output logic [31:0] host_rf_rdata_o
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_FP = 7'b1010011;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, fp_rs1_val, eff_addr;
    logic        wb_en, fp_we, take;
    logic [31:0] wb_data;
    logic        unused_addr_bits;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {instr_i[31:12], 12'd0};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    cpu_int_rf rf (
        .clk_i(clk_i), .rst_ni(sys_rst_ni), .rs1_i(rs1), .rs2_i(rs2),
        .rs1_data_o(rs1_val), .rs2_data_o(rs2_val), .we_i(wb_en), .rd_i(rd),
        .wdata_i(wb_data), .host_addr_i(host_rf_addr_i), .host_data_o(host_rf_rdata_o)
    );

    cpu_fp_rf fp_rf (
        .clk_i(clk_i), .rst_ni(sys_rst_ni), .rs1_i(rs1), .rs1_data_o(fp_rs1_val),
        .we_i(fp_we), .rd_i(rd), .wdata_i(rs1_val)
    );

    function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                        input logic [31:0] x, input logic [31:0] y);
        case (op)
            3'b000:  alu = alt ? x - y : x + y;
            3'b001:  alu = x << y[4:0];
            3'b010:  alu = {31'd0, $signed(x) < $signed(y)};
            3'b011:  alu = {31'd0, x < y};
            3'b100:  alu = x ^ y;
            3'b101:  alu = alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'b110:  alu = x | y;
            default: alu = x & y;
        endcase
    endfunction

    always_comb begin
        case (funct3)
            3'b000:  take = rs1_val == rs2_val;
            3'b001:  take = rs1_val != rs2_val;
            3'b100:  take = $signed(rs1_val) < $signed(rs2_val);
            3'b101:  take = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  take = rs1_val < rs2_val;
            3'b111:  take = rs1_val >= rs2_val;
            default: take = 1'b0;
        endcase
    end

    assign eff_addr         = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign dm_addr_o        = eff_addr[12:2];
    assign dm_wdata_o       = rs2_val;
    assign unused_addr_bits = ^{eff_addr[31:13], eff_addr[1:0]};

    always_comb begin
        wb_en         = 1'b0;
        wb_data       = '0;
        fp_we         = 1'b0;
        dm_we_o       = 1'b0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        if (valid_i) begin
            case (opcode)
                OP_LUI:   begin wb_en = 1'b1; wb_data = imm_u; end
                OP_AUIPC: begin wb_en = 1'b1; wb_data = pc_i + imm_u; end
                OP_IMM:   begin
                    wb_en   = 1'b1;
                    wb_data = alu(funct3, funct3 == 3'b101 && instr_i[30], rs1_val, imm_i);
                end
                OP_REG:   begin wb_en = 1'b1; wb_data = alu(funct3, instr_i[30], rs1_val, rs2_val); end
                OP_LOAD:  begin wb_en = 1'b1; wb_data = dm_rdata_i; end
                OP_STORE: dm_we_o = 1'b1;
                OP_BRANCH: begin redirect_o = take; redirect_pc_o = pc_i + imm_b; end
                OP_JAL:   begin
                    wb_en = 1'b1; wb_data = pc_i + 32'd4;
                    redirect_o = 1'b1; redirect_pc_o = pc_i + imm_j;
                end
                OP_JALR:  begin
                    wb_en = 1'b1; wb_data = pc_i + 32'd4;
                    redirect_o = 1'b1; redirect_pc_o = (rs1_val + imm_i) & ~32'd1;
                end
                OP_FP:    begin
                    // Only the integer/float bit moves are implemented.
                    if (funct7 == 7'b1111000) fp_we = 1'b1;
                    else if (funct7 == 7'b1110000) begin wb_en = 1'b1; wb_data = fp_rs1_val; end
                end
                default: ;
            endcase
        end
    end
endmodule

module cpu_data_mem (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [10:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    logic [31:0] mem [2048];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[addr_i] <= wdata_i;
    end

    assign rdata_o = mem[addr_i];
endmodule

module cpu_mem (
    input  logic        clk_i,
    input  logic        host_mode_i,
    input  logic        host_we_i,
    input  logic [10:0] host_addr_i,
    input  logic [31:0] host_wdata_i,
    input  logic        core_we_i,
    input  logic [10:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic [31:0] rdata_o
);
    logic        we;
    logic [10:0] addr;
    logic [31:0] wdata;

    assign we    = host_mode_i ? host_we_i : core_we_i;
    assign addr  = host_mode_i ? host_addr_i : core_addr_i;
    assign wdata = host_mode_i ? host_wdata_i : core_wdata_i;

    cpu_data_mem data_mem (.clk_i(clk_i), .we_i(we), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata_o));
endmodule

module cpu_top (
    input  logic        clk_i,
    input  logic        sys_rst_ni,
    input  logic        cpu_rst_ni,
    input  logic        host_mode_i,
    input  logic        host_im_we_i,
    input  logic        host_dm_we_i,
    input  logic [10:0] host_mem_addr_i,
    input  logic [31:0] host_wdata_i,
    input  logic [4:0]  host_rf_addr_i,
    output logic [31:0] host_im_rdata_o,
    output logic [31:0] host_dm_rdata_o,
    output logic [31:0] host_rf_rdata_o
);
    logic [31:0] imem [2048];
    logic [31:0] pc_q, pc_d, ifid_pc_q, ifid_instr_q, redirect_pc, dm_wdata;
    logic        ifid_valid_q, redirect, dm_we;
    logic [10:0] dm_addr;

    always_ff @(posedge clk_i) begin
        if (host_im_we_i) imem[host_mem_addr_i] <= host_wdata_i;
    end
    assign host_im_rdata_o = imem[host_mem_addr_i];

    // A taken branch/jump in the second stage squashes the word fetched behind it.
    assign pc_d = redirect ? redirect_pc : pc_q + 32'd4;

    always_ff @(posedge clk_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            pc_q         <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= pc_q;
            ifid_instr_q <= imem[pc_q[12:2]];
            ifid_valid_q <= !redirect;
        end
    end

    cpu_id ID (
        .clk_i(clk_i), .sys_rst_ni(sys_rst_ni), .valid_i(ifid_valid_q), .pc_i(ifid_pc_q),
        .instr_i(ifid_instr_q), .dm_rdata_i(host_dm_rdata_o), .host_rf_addr_i(host_rf_addr_i),
        .redirect_o(redirect), .redirect_pc_o(redirect_pc), .dm_we_o(dm_we),
        .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata), .host_rf_rdata_o(host_rf_rdata_o)
    );

    cpu_mem MEM (
        .clk_i(clk_i), .host_mode_i(host_mode_i), .host_we_i(host_dm_we_i),
        .host_addr_i(host_mem_addr_i), .host_wdata_i(host_wdata_i), .core_we_i(dm_we),
        .core_addr_i(dm_addr), .core_wdata_i(dm_wdata), .rdata_o(host_dm_rdata_o)
    );
endmodule

module cpu_ahb_if (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        S_HSEL,
    input  logic [31:0] S_HADDR,
    input  logic [2:0]  S_HBURST,
    input  logic [1:0]  S_HTRANS,
    input  logic [2:0]  S_HSIZE,
    input  logic        S_HWRITE,
    input  logic [31:0] S_HWDATA,
    input  logic [3:0]  S_HPROT,
    output logic        S_HREADY,
    output logic [31:0] S_HRDATA,
    output logic        S_HRESP
);
    logic [19:0] region;
    logic        is_im, is_dm, is_rf, is_ctrl, is_cpu_rstn, wr_en, rd_en, access_err;
    logic        cpu_rstn_q, cpu_rstn_d, cpu_rst_n;
    logic [31:0] rdata_q, rdata_d, im_rdata, dm_rdata, rf_rdata;
    logic        unused_inputs;

    assign region      = S_HADDR[31:12];
    assign is_im       = region == 20'h40000 || region == 20'h40001;
    assign is_dm       = region == 20'h40002 || region == 20'h40003;
    assign is_rf       = region == 20'h40004 && S_HADDR[11:7] == 5'd0;
    assign is_ctrl     = region == 20'h40008;
    assign is_cpu_rstn = is_ctrl && S_HADDR[11:0] == 12'h004;
    assign wr_en       = S_HSEL && S_HWRITE;
    assign rd_en       = S_HSEL && !S_HWRITE;
    assign cpu_rst_n   = HRESETn & cpu_rstn_q;
    assign S_HREADY    = 1'b1;
    assign S_HRDATA    = rdata_q;
    assign unused_inputs = ^{S_HBURST, S_HTRANS, S_HSIZE, S_HPROT, S_HADDR[1:0]};

`ifdef CPU_AHB_ERROR_RESP_EN
    logic hresp_q;
    assign access_err = S_HSEL && (!(is_im || is_dm || is_rf || is_ctrl) || ((is_im || is_dm) && cpu_rstn_q));
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) hresp_q <= 1'b0;
        else          hresp_q <= access_err;
    end
    assign S_HRESP = hresp_q;
`else
    assign access_err = 1'b0;
    assign S_HRESP    = 1'b0;
`endif

    always_comb begin
        cpu_rstn_d = cpu_rstn_q;
        if (wr_en && is_cpu_rstn) cpu_rstn_d = S_HWDATA[0];
    end

    // IM/DM belong to the host only while the core is held in reset.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            if (is_im && !cpu_rstn_q)      rdata_d = im_rdata;
            else if (is_dm && !cpu_rstn_q) rdata_d = dm_rdata;
            else if (is_rf)                rdata_d = rf_rdata;
            else if (is_cpu_rstn)          rdata_d = {31'd0, cpu_rstn_q};
        end
        if (access_err) rdata_d = '0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cpu_rstn_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            cpu_rstn_q <= cpu_rstn_d;
            rdata_q    <= rdata_d;
        end
    end

    cpu_top cpu_top (
        .clk_i(HCLK), .sys_rst_ni(HRESETn), .cpu_rst_ni(cpu_rst_n), .host_mode_i(!cpu_rstn_q),
        .host_im_we_i(wr_en && is_im && !cpu_rstn_q), .host_dm_we_i(wr_en && is_dm && !cpu_rstn_q),
        .host_mem_addr_i(S_HADDR[12:2]), .host_wdata_i(S_HWDATA), .host_rf_addr_i(S_HADDR[6:2]),
        .host_im_rdata_o(im_rdata), .host_dm_rdata_o(dm_rdata), .host_rf_rdata_o(rf_rdata)
    );
endmodule

// File: tb/tb_cpu_ahb_if.sv
// Directed bench for cpu_ahb_if: memory load, core run/stop, RF polling, unmapped and reset cases.

module tb_cpu_ahb_if;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        S_HSEL = 1'b0;
    logic [31:0] S_HADDR = '0;
    logic [2:0]  S_HBURST = '0;
    logic [1:0]  S_HTRANS = 2'b10;
    logic [2:0]  S_HSIZE = 3'b010;
    logic        S_HWRITE = 1'b0;
    logic [31:0] S_HWDATA = '0;
    logic [3:0]  S_HPROT = '0;
    logic        S_HREADY;
    logic [31:0] S_HRDATA;
    logic        S_HRESP;

    int checks = 0;
    int errors = 0;
    logic [31:0] prog [40];

`ifdef CPU_AHB_ERROR_RESP_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    always #5 HCLK = ~HCLK;

    cpu_ahb_if dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .S_HSEL(S_HSEL), .S_HADDR(S_HADDR),
        .S_HBURST(S_HBURST), .S_HTRANS(S_HTRANS), .S_HSIZE(S_HSIZE), .S_HWRITE(S_HWRITE),
        .S_HWDATA(S_HWDATA), .S_HPROT(S_HPROT), .S_HREADY(S_HREADY), .S_HRDATA(S_HRDATA),
        .S_HRESP(S_HRESP)
    );

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge HCLK);
        S_HSEL = 1'b1; S_HWRITE = 1'b1; S_HADDR = addr; S_HWDATA = data;
        @(posedge HCLK); #1;
        S_HSEL = 1'b0; S_HWRITE = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic resp);
        @(negedge HCLK);
        S_HSEL = 1'b1; S_HWRITE = 1'b0; S_HADDR = addr;
        @(posedge HCLK); #1;
        data = S_HRDATA; resp = S_HRESP;
        S_HSEL = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic r;
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        checks++;
        if (S_HRDATA !== 32'h0 || S_HREADY !== 1'b1 || S_HRESP !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: hrdata=%h hready=%b hresp=%b, want 0/1/0", S_HRDATA, S_HREADY, S_HRESP);
        end
        @(negedge HCLK); HRESETn = 1'b1;
        bus_read(32'h4000_8004, d, r);
        checks++;
        if (d !== 32'h0 || r !== 1'b0 || S_HREADY !== 1'b1) begin
            errors++;
            $display("FAIL reset_cpu_rstn: data=%h resp=%b hready=%b, want 0/0/1", d, r, S_HREADY);
        end
    endtask

    task automatic test_dm();
        logic [31:0] d; logic r;
        bus_write(32'h4000_2000, 32'h0000_1FF8);
        for (int i = 1; i < 2048; i++) bus_write(32'h4000_2000 + 32'(i * 4), 32'h1);
        bus_read(32'h4000_3FFC, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL dm_last_word: got %h want 00000001", d); end
        checks++;
        if (dut.cpu_top.MEM.data_mem.mem[2047] !== 32'h1) begin
            errors++; $display("FAIL dm_internal_2047: got %h want 00000001", dut.cpu_top.MEM.data_mem.mem[2047]);
        end
        bus_read(32'h4000_2000, d, r);
        checks++;
        if (d !== 32'h0000_1FF8) begin errors++; $display("FAIL dm_word0: got %h want 00001ff8", d); end
    endtask

    task automatic test_im_run();
        logic [31:0] d; logic r;
        bit done;
        prog[0] = 32'h0000_2083; prog[1] = 32'h0040_A103; prog[2] = 32'h0000_0193;
        prog[3] = 32'h0320_0213; prog[4] = 32'h0021_81B3; prog[5] = 32'hFE41_9EE3;
        prog[6] = 32'h0041_9393; prog[7] = 32'h0031_9413; prog[8] = 32'h0083_84B3;
        prog[9] = 32'h0224_8513; prog[10] = 32'h00A0_A223; prog[11] = 32'hF005_00D3;
        prog[12] = 32'h0005_0333; prog[13] = 32'h0000_006F;
        for (int i = 14; i < 40; i++) prog[i] = 32'h0000_0013;
        for (int i = 0; i < 40; i++) bus_write(32'h4000_0000 + 32'(i * 4), prog[i]);
        bus_read(32'h4000_0034, d, r);
        checks++;
        if (d !== 32'h0000_006F) begin errors++; $display("FAIL im_readback: got %h want 0000006f", d); end

        bus_write(32'h4000_8004, 32'h1);
        bus_read(32'h4000_4018, d, r);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL r6_before_set: got %h want 00000000", d); end
        done = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            bus_read(32'h4000_4018, d, r);
            if (d === 32'h0000_04D2) done = 1'b1;
            else if (d !== 32'h0) begin
                errors++; $display("FAIL r6_poll_value: got %h want 00000000 or 000004d2", d);
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL r6_poll_timeout: got %h want 000004d2", d); end
        bus_read(32'h4000_8004, d, r);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL cpu_rstn_readback: got %h want 00000001", d); end
    endtask

    task automatic test_access_while_running();
        logic [31:0] d; logic r;
        bus_write(32'h4000_2000, 32'hDEAD_BEEF);
        bus_write(32'h4000_0000, 32'hFFFF_FFFF);
        bus_read(32'h4000_2000, d, r);
        checks++;
        if (d !== 32'h0 || r !== ERR_EN) begin
            errors++; $display("FAIL dm_read_running: data=%h resp=%b want 00000000/%b", d, r, ERR_EN);
        end
        bus_read(32'h4000_400C, d, r);
        checks++;
        if (d !== 32'd50 || r !== 1'b0) begin errors++; $display("FAIL rf_r3_running: got %h want 00000032", d); end
    endtask

    task automatic test_stop();
        logic [31:0] d1, d2; logic r;
        bus_write(32'h4000_8004, 32'h0);
        bus_read(32'h4000_3FFC, d1, r);
        bus_read(32'h4000_3FFC, d2, r);
        checks++;
        if (d1 !== 32'h0000_04D2 || d2 !== 32'h0000_04D2) begin
            errors++; $display("FAIL stop_result_twice: got %h,%h want 000004d2", d1, d2);
        end
        bus_read(32'h4000_2000, d1, r);
        checks++;
        if (d1 !== 32'h0000_1FF8) begin errors++; $display("FAIL dm_write_dropped: got %h want 00001ff8", d1); end
        bus_read(32'h4000_0000, d1, r);
        checks++;
        if (d1 !== 32'h0000_2083) begin errors++; $display("FAIL im_write_dropped: got %h want 00002083", d1); end
        bus_read(32'h4000_4018, d1, r);
        checks++;
        if (d1 !== 32'h0000_04D2) begin errors++; $display("FAIL rf_r6_after_stop: got %h want 000004d2", d1); end
        checks++;
        if (dut.cpu_top.ID.fp_rf.REG_F[1] !== 32'h0000_04D2) begin
            errors++; $display("FAIL fp_f1: got %h want 000004d2", dut.cpu_top.ID.fp_rf.REG_F[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c; logic r;
        bus_read(32'h4000_4004, a, r);
        bus_read(32'h4000_4008, b, r);
        bus_read(32'h4000_4028, c, r);
        checks++;
        if (a !== 32'h0000_1FF8 || b !== 32'h1 || c !== 32'h0000_04D2) begin
            errors++; $display("FAIL back_to_back: got %h,%h,%h want 00001ff8,00000001,000004d2", a, b, c);
        end
        bus_write(32'h4000_4008, 32'h1234_5678);
        checks++;
        if (S_HRDATA !== 32'h0000_04D2) begin errors++; $display("FAIL hrdata_held: got %h want 000004d2", S_HRDATA); end
        bus_read(32'h4000_4008, a, r);
        checks++;
        if (a !== 32'h1) begin errors++; $display("FAIL rf_write_ignored: got %h want 00000001", a); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d; logic r;
        bus_write(32'h4000_6000, 32'hCAFE_F00D);
        bus_read(32'h4000_6000, d, r);
        checks++;
        if (d !== 32'h0 || r !== ERR_EN) begin
            errors++; $display("FAIL unmapped_read: data=%h resp=%b want 00000000/%b", d, r, ERR_EN);
        end
        bus_read(32'h4000_4080, d, r);
        checks++;
        if (d !== 32'h0 || r !== ERR_EN) begin
            errors++; $display("FAIL rf_out_of_range: data=%h resp=%b want 00000000/%b", d, r, ERR_EN);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic r;
        bus_read(32'h4000_4004, d, r);
        @(negedge HCLK);
        S_HSEL = 1'b1; S_HWRITE = 1'b0; S_HADDR = 32'h4000_4028;
        #2 HRESETn = 1'b0;
        #1;
        checks++;
        if (S_HRDATA !== 32'h0) begin errors++; $display("FAIL reset_mid_hrdata: got %h want 00000000", S_HRDATA); end
        @(posedge HCLK); #1;
        S_HSEL = 1'b0;
        checks++;
        if (S_HRDATA !== 32'h0) begin errors++; $display("FAIL reset_mid_discard: got %h want 00000000", S_HRDATA); end
        @(negedge HCLK); HRESETn = 1'b1;
        bus_read(32'h4000_3FFC, d, r);
        checks++;
        if (d !== 32'h0000_04D2) begin errors++; $display("FAIL dm_after_reset: got %h want 000004d2", d); end
    endtask

    initial begin
        test_reset();
        test_dm();
        test_im_run();
        test_access_while_running();
        test_stop();
        test_back_to_back();
        test_unmapped();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
